// File: rtl/ddrc_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : ddrc_seq_pkg                                                 |
// | Description : Shared state encoding and default widths for the DDR         |
// |               sequencer arbiter and its round-robin picker.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package ddrc_seq_pkg;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_RUN  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_WAIT = 2'd2;
    localparam logic [c_STATE_W-1:0] c_DONE = 2'd3;

    localparam int c_ADDR_BITS_DEF = 11;
    localparam int c_CHN_BITS_DEF  = 4;

endpackage

`default_nettype wire

// File: rtl/ddrc_rr_pick.sv
// +----------------------------------------------------------------------------+
// | Module      : ddrc_rr_pick                                                 |
// | Description : Combinational round-robin picker: first set request at or    |
// |               above rr_ptr, wrapping modulo NUM_REQ.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module ddrc_rr_pick
    import ddrc_seq_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CHN_BITS = c_CHN_BITS_DEF
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [CHN_BITS-1:0] rr_ptr,
    output logic [CHN_BITS-1:0] winner,
    output logic                any_req
);

    localparam logic [CHN_BITS:0] c_NUM_REQ = (CHN_BITS+1)'(NUM_REQ);

    logic [NUM_REQ-1:0]  w_rot;
    logic [CHN_BITS-1:0] w_off;
    logic [CHN_BITS:0]   w_sum;

    // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    always_comb begin
        w_rot   = NUM_REQ'({req, req} >> rr_ptr);
        w_off   = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                any_req = 1'b1;
                w_off   = CHN_BITS'(k);
            end
        end
        w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
        if (w_sum >= c_NUM_REQ) begin
            w_sum = w_sum - c_NUM_REQ;
        end
        winner = w_sum[CHN_BITS-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/ddrc_seq_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : ddrc_seq_arbiter                                             |
// | Description : Round-robin sharing of the single DDR sequencer between      |
// |               NUM_REQ requesters, one sequence in flight at a time.        |
// |               Optional watchdog: define DDRC_SEQ_TIMEOUT_EN.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module ddrc_seq_arbiter
    import ddrc_seq_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BITS      = c_ADDR_BITS_DEF,
    parameter int CHN_BITS       = c_CHN_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           mclk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           err,
    output logic [ADDR_BITS-1:0]           run_addr,
    output logic [CHN_BITS-1:0]            run_chn,
    output logic                           run_seq,
    input  logic                           run_done,
    output logic                           busy
);

    if (((2 ** CHN_BITS) < NUM_REQ) || (NUM_REQ < 1) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
        $error("ddrc_seq_arbiter: illegal parameter combination");
    end

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [CHN_BITS-1:0]  r_rr_ptr;
    logic [CHN_BITS-1:0]  r_run_chn;
    logic [ADDR_BITS-1:0] r_run_addr;
    logic [CHN_BITS-1:0]  w_winner;
    logic                 w_any_req;
    logic [ADDR_BITS-1:0] w_sel_addr;
    logic                 w_timeout;
    logic                 w_err_flag;

    ddrc_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .CHN_BITS (CHN_BITS)
    ) u_pick (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == CHN_BITS'(i)) begin
                w_sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

`ifdef DDRC_SEQ_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES);

    logic [c_WD_W-1:0] r_wd;
    logic              r_err;

    assign w_timeout  = (r_state == c_WAIT) && (r_wd == c_WD_W'(TIMEOUT_CYCLES - 1));
    assign w_err_flag = r_err;

    // A run_done arriving on the timeout cycle counts as a normal completion.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else if (r_state == c_RUN) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else if (r_state == c_WAIT) begin
            r_wd  <= r_wd + c_WD_W'(1);
            r_err <= w_timeout & ~run_done;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign w_err_flag = 1'b0;
`endif

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req) w_next_state = c_RUN;
            c_RUN:   w_next_state = c_WAIT;
            c_WAIT:  if (run_done || w_timeout) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        run_seq = (r_state == c_RUN);
        busy    = (r_state != c_IDLE);
        err     = (r_state == c_DONE) && w_err_flag;
        ack     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (r_state == c_DONE) && (r_run_chn == CHN_BITS'(i));
        end
    end

    // Grant fields are captured once in IDLE and held until the next grant.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_run_chn  <= '0;
            r_run_addr <= '0;
        end else begin
            if ((r_state == c_IDLE) && w_any_req) begin
                r_run_chn  <= w_winner;
                r_run_addr <= w_sel_addr;
            end
            if (r_state == c_DONE) begin
                r_rr_ptr <= (r_run_chn == CHN_BITS'(NUM_REQ - 1)) ? '0 : r_run_chn + CHN_BITS'(1);
            end
        end
    end

    assign run_addr = r_run_addr;
    assign run_chn  = r_run_chn;

endmodule

`default_nettype wire
